// File: rtl/neopixel_frame_ctrl.sv
// Double-buffered pixel store and frame sequencer for neopixel_tx_fsm: NUM_PIXELS data words then LATCH_WORDS latch words.
// Bank swaps and frame starts are serviced only in IDLE, so a frame in flight always completes from its own bank.
module neopixel_frame_ctrl #(
  parameter int NUM_PIXELS   = 18,
  parameter int ADDR_W       = 5,
  parameter int LATCH_WORDS  = 2,
  parameter int FRAME_PERIOD = 20460,
  parameter int PER_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  input  logic              start,
  input  logic              auto_en,
  input  logic              rd_next,
  output logic              tx_enable,
  output logic              empty_flg,
  output logic [23:0]       neo_dIn,
  output logic              rgb_msgTyp,
  output logic              busy,
  output logic              frame_done,
  output logic              front_sel
);

  localparam int LC_W = (LATCH_WORDS > 1) ? $clog2(LATCH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [23:0]       r_bank [2][NUM_PIXELS];
  logic              r_front_sel;
  logic              r_start_pend;
  logic              r_commit_pend;
  logic              r_frame_done;
  logic [ADDR_W-1:0] r_index;
  logic [LC_W-1:0]   r_latch_cnt;
  logic [PER_W-1:0]  r_timer;

  logic              w_back_sel;
  logic              w_timer_exp;
  logic              w_do_swap;
  logic              w_take_start;
  logic              w_adv_pix;
  logic              w_enter_latch;
  logic              w_dec_latch;
  logic              w_frame_end;
  logic [23:0]       w_front_pix;

  assign w_back_sel  = ~r_front_sel;
  assign w_timer_exp = auto_en && (r_timer == PER_W'(FRAME_PERIOD - 1));
  assign busy        = (r_state != IDLE);
  assign frame_done  = r_frame_done;
  assign front_sel   = r_front_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (!auto_en || w_timer_exp) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A new request arriving in the same cycle one is taken re-arms the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_pend  <= 1'b0;
      r_commit_pend <= 1'b0;
      r_front_sel   <= 1'b0;
    end else begin
      r_start_pend  <= (r_start_pend && !w_take_start) || start || w_timer_exp;
      r_commit_pend <= (r_commit_pend && !w_do_swap) || commit;
      if (w_do_swap) begin
        r_front_sel <= ~r_front_sel;
      end
    end
  end

  // Out-of-range addresses match no entry and so fall through untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_PIXELS; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          r_bank[w_back_sel][i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    w_front_pix = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (r_index == ADDR_W'(i)) begin
        w_front_pix = r_bank[r_front_sel][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_latch_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_end;
      if (w_take_start) begin
        r_index <= '0;
      end else if (w_adv_pix) begin
        r_index <= r_index + 1'b1;
      end
      if (w_enter_latch) begin
        r_latch_cnt <= LC_W'(LATCH_WORDS - 1);
      end else if (w_dec_latch) begin
        r_latch_cnt <= r_latch_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_do_swap     = 1'b0;
    w_take_start  = 1'b0;
    w_adv_pix     = 1'b0;
    w_enter_latch = 1'b0;
    w_dec_latch   = 1'b0;
    w_frame_end   = 1'b0;
    tx_enable     = 1'b0;
    empty_flg     = 1'b1;
    rgb_msgTyp    = 1'b0;
    neo_dIn       = '0;
    case (r_state)
      IDLE: begin
        // Commit wins over start so the freshly committed bank is the one sent.
        if (r_commit_pend) begin
          w_do_swap = 1'b1;
        end else if (r_start_pend) begin
          w_take_start = 1'b1;
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        tx_enable  = 1'b1;
        empty_flg  = 1'b0;
        rgb_msgTyp = 1'b1;
        neo_dIn    = w_front_pix;
        if (rd_next) begin
          if (r_index == ADDR_W'(NUM_PIXELS - 1)) begin
            w_enter_latch = 1'b1;
            w_state_nxt   = LATCH;
          end else begin
            w_adv_pix = 1'b1;
          end
        end
      end
      LATCH: begin
        tx_enable = 1'b1;
        empty_flg = 1'b0;
        if (rd_next) begin
          if (r_latch_cnt == '0) begin
            w_frame_end = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_dec_latch = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Bench for neopixel_frame_ctrl: table vectors, directed corner sequences and random frames against a bank/frame model.
module tb_neopixel_frame_ctrl;
  localparam int NP = 18;
  localparam int LW = 2;
  localparam int NW = NP + LW;
  localparam int PERIOD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        rd_next = 1'b0;
  logic        tx_enable, empty_flg, rgb_msgTyp, busy, frame_done, front_sel;
  logic [23:0] neo_dIn;

  neopixel_frame_ctrl #(
    .NUM_PIXELS(NP), .ADDR_W(5), .LATCH_WORDS(LW), .FRAME_PERIOD(PERIOD), .PER_W(16)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .start(start), .auto_en(auto_en), .rd_next(rd_next),
    .tx_enable(tx_enable), .empty_flg(empty_flg), .neo_dIn(neo_dIn),
    .rgb_msgTyp(rgb_msgTyp), .busy(busy), .frame_done(frame_done), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: two banks, front index, a pending commit latched mid-frame.
  logic [23:0] mb [0:1][0:31];
  bit          mfs;
  bit          m_cpend;
  logic [23:0] cap [0:31];

  int cyc = 0;
  int rises[$];
  int falls[$];
  int fd_cnt = 0;
  logic prev_te = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_enable && !prev_te) rises.push_back(cyc);
    if (!tx_enable && prev_te) falls.push_back(cyc);
    prev_te = tx_enable;
    if (frame_done) fd_cnt++;
  end

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          chk_idx;
    logic [23:0] exp;
  } wvec_t;

  wvec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) mb[b][i] = '0;
    mfs = 1'b0;
    m_cpend = 1'b0;
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < NP) mb[mfs ? 0 : 1][a] = d;
  endtask

  task automatic commit_idle();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick();
    mfs = ~mfs;
    chk("commit_front", front_sel, mfs);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for a frame, checks each word against the model, pulses rd_next every gap cycles.
  task automatic consume_frame(input int gap, input int stop_at = -1, input int hook_w = -1,
                               input int hook_addr = -1, input logic [23:0] hook_dat = '0,
                               input bit hook_cmt = 1'b0, input int hook_starts = 0);
    int waitc = 0;
    bit fs;
    logic [23:0] exp_d;
    while (!tx_enable && waitc < 200) begin
      tick();
      waitc++;
    end
    if (!tx_enable) begin
      chk("frame_start_timeout", tx_enable, 1);
      return;
    end
    chk("frame_front", front_sel, mfs);
    fs = mfs;
    for (int w = 0; w < NW; w++) begin
      if (w == stop_at) return;
      exp_d = (w < NP) ? mb[fs][w] : 24'h0;
      chk($sformatf("w%0d_dat", w), neo_dIn, exp_d);
      chk($sformatf("w%0d_typ", w), rgb_msgTyp, (w < NP) ? 1 : 0);
      chk($sformatf("w%0d_te", w), tx_enable, 1);
      chk($sformatf("w%0d_empty", w), empty_flg, 0);
      chk($sformatf("w%0d_fd", w), frame_done, 0);
      cap[w] = neo_dIn;
      if (w == hook_w) begin
        if (hook_addr >= 0) wr(hook_addr, hook_dat);
        if (hook_cmt) begin
          commit = 1'b1; tick(); commit = 1'b0;
          m_cpend = 1'b1;
        end
        for (int s = 0; s < hook_starts; s++) begin
          start = 1'b1; tick(); start = 1'b0; tick();
        end
      end
      repeat (gap - 1) tick();
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
    end
    chk("end_fd", frame_done, 1);
    chk("end_te", tx_enable, 0);
    chk("end_empty", empty_flg, 1);
    chk("end_busy", busy, 0);
    chk("end_dat", neo_dIn, 0);
    tick(); tick();
    chk("end_fd_clear", frame_done, 0);
    if (m_cpend) begin
      mfs = ~mfs;
      m_cpend = 1'b0;
    end
    chk("end_front", front_sel, mfs);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int r0, fd0;
    logic [23:0] old3;

    tbl[0] = '{2,  24'h0A0B0C, 2,  24'h0A0B0C};
    tbl[1] = '{13, 24'h123456, 13, 24'h123456};
    tbl[2] = '{17, 24'hABCDEF, 17, 24'hABCDEF};
    tbl[3] = '{0,  24'hFFFFFF, 0,  24'hFFFFFF};
    tbl[4] = '{20, 24'hDEAD01, 2,  24'h0A0B0C};
    tbl[5] = '{31, 24'hDEAD02, 13, 24'h123456};
    tbl[6] = '{18, 24'hDEAD03, 0,  24'hFFFFFF};
    tbl[7] = '{16, 24'h00FF00, 16, 24'h00FF00};

    model_clear();
    tick(); tick();
    chk("rst_te", tx_enable, 0);
    chk("rst_empty", empty_flg, 1);
    chk("rst_dat", neo_dIn, 0);
    chk("rst_typ", rgb_msgTyp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_front", front_sel, 0);
    rst = 1'b1;
    tick();

    // Pixel i = i, commit and start together: one swap cycle before data.
    for (int i = 0; i < NP; i++) wr(i, 24'(i));
    commit = 1'b1; start = 1'b1;
    tick();
    commit = 1'b0; start = 1'b0;
    chk("t1_c0_te", tx_enable, 0);
    chk("t1_c0_front", front_sel, 0);
    tick();
    chk("t1_c1_te", tx_enable, 0);
    chk("t1_c1_typ", rgb_msgTyp, 0);
    chk("t1_c1_front", front_sel, 1);
    tick();
    chk("t1_c2_te", tx_enable, 1);
    mfs = 1'b1;
    fd0 = fd_cnt;
    consume_frame(4);
    chk("t1_fd_once", fd_cnt - fd0, 1);
    chk("t1_front", front_sel, 1);

    // Write + commit mid-frame: old pixel 3 now, new one next frame.
    pulse_start();
    chk("t2_lat0_te", tx_enable, 0);
    tick();
    chk("t2_lat1_te", tx_enable, 1);
    consume_frame(2, -1, 1, 3, 24'hFF0000, 1'b1);
    old3 = cap[3];
    chk("t2_px3_old", old3, 24'h000003);
    chk("t2_front_toggled", front_sel, 0);
    pulse_start();
    consume_frame(1);
    chk("t2_px3_new", cap[3], 24'hFF0000);

    // Three start pulses during SEND yield exactly one extra frame.
    r0 = rises.size();
    pulse_start();
    consume_frame(1, -1, 4, -1, 24'h0, 1'b0, 3);
    consume_frame(1);
    repeat (80) tick();
    chk("t5_frames", rises.size() - r0, 2);
    chk("t5_idle_te", tx_enable, 0);

    // Table: out-of-range writes must not alias onto in-range pixels.
    for (int k = 0; k < 8; k++) wr(tbl[k].addr, tbl[k].data);
    commit_idle();
    pulse_start();
    consume_frame(3);
    for (int k = 0; k < 8; k++)
      chk($sformatf("tbl%0d_px%0d", k, tbl[k].chk_idx), cap[tbl[k].chk_idx], tbl[k].exp);

    // Random writes, commits and frames.
    for (int it = 0; it < 12; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++) wr($urandom_range(0, 31), 24'($urandom));
      if ($urandom_range(0, 1) == 1) commit_idle();
      pulse_start();
      consume_frame($urandom_range(1, 3), -1, $urandom_range(0, NW - 1),
                    ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 31),
                    24'($urandom), 1'($urandom_range(0, 1)));
    end

    // Auto refresh: short frames start PERIOD apart; long frames run back-to-back.
    rises.delete(); falls.delete();
    auto_en = 1'b1;
    for (int f = 0; f < 3; f++) consume_frame(1);
    if (rises.size() >= 3) begin
      chk("t3_period01", rises[1] - rises[0], PERIOD);
      chk("t3_period12", rises[2] - rises[1], PERIOD);
    end else begin
      chk("t3_rise_count", rises.size(), 3);
    end
    rises.delete(); falls.delete();
    for (int f = 0; f < 3; f++) consume_frame(5);
    if (rises.size() >= 3 && falls.size() >= 2) begin
      chk("t3_gap0", rises[1] - falls[0], 1);
      chk("t3_gap1", rises[2] - falls[1], 1);
    end else begin
      chk("t3_b2b_count", rises.size(), 3);
    end
    auto_en = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    model_clear();

    // Reset mid-frame at pixel index 7, then both banks read back zero.
    for (int i = 0; i < NP; i++) wr(i, 24'h100000 + 24'(i));
    commit_idle();
    for (int i = 0; i < NP; i++) wr(i, 24'h200000 + 24'(i));
    pulse_start();
    consume_frame(1, 7);
    chk("t6_pre_dat", neo_dIn, 24'h100007);
    rst = 1'b0;
    #1;
    chk("t6_te", tx_enable, 0);
    chk("t6_empty", empty_flg, 1);
    chk("t6_busy", busy, 0);
    chk("t6_front", front_sel, 0);
    chk("t6_dat", neo_dIn, 0);
    tick(); tick();
    rst = 1'b1;
    model_clear();
    tick();
    pulse_start();
    consume_frame(1);
    commit_idle();
    pulse_start();
    consume_frame(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
